// File: rtl/enc_block_sequencer.sv
// Per-block position sequencer for the turbo encoder: counts data bits of one code block,
// flags the last data cycle, walks the trellis-termination tail and pulses completion.
module enc_block_sequencer #(
    parameter int CNT_W    = 13,
    parameter int K_SMALL  = 1056,
    parameter int K_LARGE  = 6144,
    parameter int TAIL_LEN = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             mode,
    input  logic             en,
    input  logic             abort,
    output logic             switch,
    output logic             tail_active,
    output logic [1:0]       tail_idx,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SMALL = CNT_W'(K_SMALL - 1);
    localparam logic [CNT_W-1:0] LAST_LARGE = CNT_W'(K_LARGE - 1);
    localparam logic [1:0]       TAIL_LAST  = 2'(TAIL_LEN - 1);

    // The tail index port is two bits wide, so the tail may be at most four cycles long.
    if (K_LARGE > 2**CNT_W || K_SMALL > 2**CNT_W) begin : g_bad_cnt_w
        $error("enc_block_sequencer: CNT_W too narrow for the block sizes");
    end
    if (TAIL_LEN < 1 || TAIL_LEN > 4) begin : g_bad_tail_len
        $error("enc_block_sequencer: TAIL_LEN must be 1..4");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       tail_q;
    logic             mode_q;
    logic             err_q;

    logic [CNT_W-1:0] last_cnt;
    logic             at_last;
    logic             tail_end;
    logic             in_block;
    logic             do_abort;

    assign last_cnt = mode_q ? LAST_LARGE : LAST_SMALL;
    assign at_last  = (cnt_q == last_cnt);
    assign tail_end = (tail_q == TAIL_LAST);
    assign in_block = (state == DATA) || (state == TAIL);
    assign do_abort = abort && (state != IDLE);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (do_abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nxt = DATA;
                DATA: if (en && at_last) state_nxt = TAIL;
                TAIL: if (tail_end) state_nxt = DONE;
                DONE: state_nxt = start ? DATA : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath registers: count, tail index, latched block size and the busy-start flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q  <= '0;
            tail_q <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= start && in_block && !abort;
            if (do_abort) begin
                cnt_q  <= '0;
                tail_q <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            cnt_q  <= '0;
                            mode_q <= mode;
                        end
                    end
                    DATA: begin
                        // cnt parks at K-1 through the tail and DONE; it never wraps.
                        if (en && !at_last) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (en && at_last) begin
                            tail_q <= '0;
                        end
                    end
                    TAIL: begin
                        tail_q <= tail_end ? 2'd0 : tail_q + 2'd1;
                    end
                    DONE: begin
                        cnt_q <= '0;
                        if (start) begin
                            mode_q <= mode;
                        end
                    end
                    default: begin
                        cnt_q  <= '0;
                        tail_q <= '0;
                    end
                endcase
            end
        end
    end

    // Outputs decode registered state only; there is no input-to-output path.
    always_comb begin
        switch      = (state == DATA) && at_last;
        tail_active = (state == TAIL);
        tail_idx    = tail_q;
        cnt         = cnt_q;
        busy        = in_block;
        done        = (state == DONE);
        err         = err_q;
    end

    a_cnt_range : assert property (@(posedge clk) disable iff (clr) cnt_q <= last_cnt);
    a_done_pulse: assert property (@(posedge clk) disable iff (clr) done |=> !done);
    a_tail_zero : assert property (@(posedge clk) disable iff (clr) !tail_active |-> tail_idx == 2'd0);

endmodule

// File: tb/tb_enc_block_sequencer.sv
// Self-checking bench for enc_block_sequencer: directed block scenarios plus random traffic,
// all checked every cycle against a progress-count model of a code block.
module tb_enc_block_sequencer;

    localparam int CNT_W    = 13;
    localparam int K_SMALL  = 1056;
    localparam int K_LARGE  = 6144;
    localparam int TAIL_LEN = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             mode;
    logic             en;
    logic             abort;
    logic             switch;
    logic             tail_active;
    logic [1:0]       tail_idx;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic             err;

    int compared   = 0;
    int mismatched = 0;

    // Model: a block is "d data bits accepted, then t tail cycles spent"; d==K, t==TAIL_LEN is DONE.
    bit m_in;
    int m_k;
    int m_d;
    int m_t;
    bit m_err;

    always #5 clk = ~clk;

    enc_block_sequencer #(
        .CNT_W   (CNT_W),
        .K_SMALL (K_SMALL),
        .K_LARGE (K_LARGE),
        .TAIL_LEN(TAIL_LEN)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .mode       (mode),
        .en         (en),
        .abort      (abort),
        .switch     (switch),
        .tail_active(tail_active),
        .tail_idx   (tail_idx),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in  = 1'b0;
        m_k   = K_SMALL;
        m_d   = 0;
        m_t   = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit e, input bit a, input bit md);
        bit nerr;
        nerr = 1'b0;
        if (!m_in) begin
            if (s) begin
                m_in = 1'b1;
                m_k  = md ? K_LARGE : K_SMALL;
                m_d  = 0;
                m_t  = 0;
            end
        end else if (a) begin
            m_in = 1'b0;
        end else if (m_d < m_k) begin
            nerr = s;
            if (e) m_d++;
        end else if (m_t < TAIL_LEN) begin
            nerr = s;
            m_t++;
        end else if (s) begin
            m_k = md ? K_LARGE : K_SMALL;
            m_d = 0;
            m_t = 0;
        end else begin
            m_in = 1'b0;
        end
        m_err = nerr;
    endtask

    task automatic compare_all();
        bit data_ph;
        bit tail_ph;
        bit done_ph;
        int e_cnt;
        data_ph = m_in && (m_d < m_k);
        tail_ph = m_in && (m_d == m_k) && (m_t < TAIL_LEN);
        done_ph = m_in && (m_t == TAIL_LEN);
        e_cnt   = !m_in ? 0 : ((m_d < m_k) ? m_d : m_k - 1);
        check("switch", switch, data_ph && (m_d == m_k - 1));
        check("tail_active", tail_active, tail_ph);
        check("tail_idx", tail_idx, tail_ph ? m_t : 0);
        check("cnt", cnt, e_cnt);
        check("busy", busy, data_ph || tail_ph);
        check("done", done, done_ph);
        check("err", err, m_err);
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic cycle(input bit s, input bit e, input bit a, input bit md);
        start = s;
        en    = e;
        abort = a;
        mode  = md;
        @(posedge clk);
        model_step(s, e, a, md);
        @(negedge clk);
        compare_all();
    endtask

    // Runs with en high on one of every `period` cycles until the block returns to IDLE.
    task automatic run_to_idle(input string tag, input int period, output int n, output int sw,
                               output int dn, output int tl, output int sw_cnt);
        n = 0; sw = 0; dn = 0; tl = 0; sw_cnt = -1;
        for (int i = 0; i < 20000; i++) begin
            cycle(1'b0, (i % period) == period - 1, 1'b0, 1'b0);
            n++;
            if (switch) begin
                sw++;
                sw_cnt = cnt;
            end
            if (done) dn++;
            if (tail_active) tl++;
            if (!busy && !done) return;
        end
        check({tag, "_timeout"}, n, 0);
    endtask

    task automatic run_to_cnt(input string tag, input int target);
        for (int i = 0; i < 8000; i++) begin
            if (cnt == target) return;
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check({tag, "_reach_cnt"}, cnt, target);
    endtask

    int n, sw, dn, tl, sw_cnt;

    initial begin
        clr = 1'b1; start = 1'b0; mode = 1'b0; en = 1'b0; abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        clr = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b1);

        // T1: small block, en always high
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_start_busy", busy, 1);
        run_to_idle("t1", 1, n, sw, dn, tl, sw_cnt);
        check("t1_len", n, 1060);
        check("t1_switch_cycles", sw, 1);
        check("t1_switch_cnt", sw_cnt, K_SMALL - 1);
        check("t1_tail_cycles", tl, TAIL_LEN);
        check("t1_done_cycles", dn, 1);

        // T2: large block, en every other cycle
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_to_idle("t2", 2, n, sw, dn, tl, sw_cnt);
        check("t2_len", n, 12292);
        check("t2_switch_cycles", sw, 2);
        check("t2_switch_cnt", sw_cnt, K_LARGE - 1);
        check("t2_done_cycles", dn, 1);

        // T3: start while busy
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_cnt("t3", 500);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("t3_err_pulse", err, 1);
        check("t3_cnt_kept", cnt, 501);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_err_clear", err, 0);
        run_to_idle("t3", 1, n, sw, dn, tl, sw_cnt);
        check("t3_switch_cnt", sw_cnt, K_SMALL - 1);
        check("t3_done_cycles", dn, 1);

        // T4: asynchronous clear mid-tail
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (tail_active && tail_idx == 2'd1) break;
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("t4_reach_tail1", tail_idx, 1);
        #2 clr = 1'b1;
        #1;
        check("t4_clr_switch", switch, 0);
        check("t4_clr_tail_active", tail_active, 0);
        check("t4_clr_tail_idx", tail_idx, 0);
        check("t4_clr_cnt", cnt, 0);
        check("t4_clr_busy", busy, 0);
        check("t4_clr_done", done, 0);
        check("t4_clr_err", err, 0);
        model_reset();
        @(negedge clk);
        compare_all();
        clr = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_idle("t4", 1, n, sw, dn, tl, sw_cnt);
        check("t4_len", n, 1060);

        // T5: start held at DONE, mode wiggled mid-block
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (done) break;
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("t5_reach_done", done, 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_restart_busy", busy, 1);
        check("t5_restart_cnt", cnt, 0);
        run_to_cnt("t5", 10);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        run_to_idle("t5", 1, n, sw, dn, tl, sw_cnt);
        check("t5_switch_cnt", sw_cnt, K_SMALL - 1);
        check("t5_len", n, 1060 - 12);

        // T6: abort with start also high
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        run_to_cnt("t6", 300);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_cnt", cnt, 0);
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            if (done) dn++;
        end
        check("t6_no_done", dn, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_to_idle("t6", 1, n, sw, dn, tl, sw_cnt);
        check("t6_len", n, 1060);

        // Random traffic, every cycle checked against the model
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(4999) == 0) begin
                #2 clr = 1'b1;
                model_reset();
                #1 compare_all();
                @(negedge clk);
                clr = 1'b0;
            end
            cycle($urandom_range(15) == 0, $urandom_range(3) != 0,
                  $urandom_range(399) == 0, $urandom_range(3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
